// File: rtl/usb_byte_receiver.sv
// USB receive byte path: samples D+/D- at mid-bit, NRZI-decodes, checks sync,
// removes stuffed bits, assembles LSB-first bytes and recognises EOP.
module usb_byte_receiver #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       rcv_en,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [7:0] byte_count,
  output logic       sync_detected,
  output logic       eop_detected,
  output logic       rcv_error,
  output logic       rcv_active
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_SAMPLE = TW'(SAMPLE_POINT);
  localparam logic [OW-1:0] ONES_LIMIT = OW'(STUFF_LIMIT);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERROR} state_t;

  state_t        state;
  logic          dp_meta, dp_sync, dm_meta, dm_sync, dp_last, dm_last;
  logic [TW-1:0] bit_timer;
  logic          prev_level;
  logic [OW-1:0] ones_count;
  logic [2:0]    bit_count;
  logic [7:0]    shift_reg;
  logic          byte_ready, se0_seen, eop_second;

  logic line_j, line_k, line_se0, line_se1;
  logic sample, nrzi_bit, start_edge, dp_edge;
  logic [7:0] shifted;

  assign line_j     = dp_sync & ~dm_sync;
  assign line_k     = ~dp_sync & dm_sync;
  assign line_se0   = ~dp_sync & ~dm_sync;
  assign line_se1   = dp_sync & dm_sync;
  assign sample     = (state != IDLE) && (bit_timer == TIMER_SAMPLE);
  assign nrzi_bit   = (dp_sync == prev_level);
  assign shifted    = {nrzi_bit, shift_reg[7:1]};
  assign start_edge = rcv_en && dp_last && !dm_last && line_k;
  assign dp_edge    = (dp_sync != dp_last);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dp_meta       <= 1'b1;
      dp_sync       <= 1'b1;
      dp_last       <= 1'b1;
      dm_meta       <= 1'b0;
      dm_sync       <= 1'b0;
      dm_last       <= 1'b0;
      state         <= IDLE;
      bit_timer     <= '0;
      prev_level    <= 1'b1;
      ones_count    <= '0;
      bit_count     <= '0;
      shift_reg     <= '0;
      byte_ready    <= 1'b0;
      se0_seen      <= 1'b0;
      eop_second    <= 1'b0;
      byte_out      <= '0;
      byte_valid    <= 1'b0;
      byte_count    <= '0;
      sync_detected <= 1'b0;
      eop_detected  <= 1'b0;
      rcv_error     <= 1'b0;
      rcv_active    <= 1'b0;
    end else begin
      dp_meta       <= d_plus;
      dp_sync       <= dp_meta;
      dp_last       <= dp_sync;
      dm_meta       <= d_minus;
      dm_sync       <= dm_meta;
      dm_last       <= dm_sync;
      byte_valid    <= 1'b0;
      sync_detected <= 1'b0;
      eop_detected  <= 1'b0;
      rcv_error     <= 1'b0;
      byte_ready    <= 1'b0;

      if (!rcv_en) begin
        state      <= IDLE;
        rcv_active <= 1'b0;
        bit_timer  <= '0;
        prev_level <= 1'b1;
        ones_count <= '0;
        bit_count  <= '0;
        se0_seen   <= 1'b0;
        eop_second <= 1'b0;
      end else begin
        // Any D+ transition while receiving re-centres the sample point.
        if (rcv_active && dp_edge)
          bit_timer <= '0;
        else if (bit_timer == TIMER_LAST)
          bit_timer <= '0;
        else
          bit_timer <= bit_timer + TW'(1);

        if (sample)
          prev_level <= dp_sync;

        if (byte_ready) begin
          byte_out   <= shift_reg;
          byte_valid <= 1'b1;
          byte_count <= byte_count + 8'd1;
        end

        case (state)
          IDLE: begin
            if (start_edge) begin
              state      <= SYNC;
              rcv_active <= 1'b1;
              bit_timer  <= '0;
              prev_level <= 1'b1;
              bit_count  <= '0;
            end
          end

          SYNC: begin
            if (sample) begin
              shift_reg <= shifted;
              bit_count <= bit_count + 3'd1;
              if (bit_count == 3'd7) begin
                bit_count <= '0;
                if (shifted == 8'h80) begin
                  state         <= DATA;
                  sync_detected <= 1'b1;
                  byte_count    <= '0;
                  ones_count    <= '0;
                end else begin
                  state      <= ERROR;
                  rcv_active <= 1'b0;
                  rcv_error  <= 1'b1;
                  se0_seen   <= 1'b0;
                end
              end
            end
          end

          DATA: begin
            if (sample) begin
              if (line_se1 || (line_se0 && (bit_count != 3'd0 || ones_count == ONES_LIMIT))) begin
                state      <= ERROR;
                rcv_active <= 1'b0;
                rcv_error  <= 1'b1;
                se0_seen   <= line_se0;
              end else if (line_se0) begin
                state      <= EOP;
                eop_second <= 1'b0;
              end else if (ones_count == ONES_LIMIT) begin
                // Six ones in a row: this bit must be a stuffed zero.
                if (nrzi_bit) begin
                  state      <= ERROR;
                  rcv_active <= 1'b0;
                  rcv_error  <= 1'b1;
                  se0_seen   <= 1'b0;
                end else begin
                  ones_count <= '0;
                end
              end else begin
                shift_reg  <= shifted;
                ones_count <= nrzi_bit ? ones_count + OW'(1) : '0;
                if (bit_count == 3'd7) begin
                  bit_count  <= '0;
                  byte_ready <= 1'b1;
                end else begin
                  bit_count <= bit_count + 3'd1;
                end
              end
            end
          end

          EOP: begin
            if (sample) begin
              if (!eop_second && line_se0) begin
                eop_second <= 1'b1;
              end else if (eop_second && line_j) begin
                state        <= IDLE;
                rcv_active   <= 1'b0;
                eop_detected <= 1'b1;
              end else begin
                state      <= ERROR;
                rcv_active <= 1'b0;
                rcv_error  <= 1'b1;
                se0_seen   <= line_se0;
              end
            end
          end

          ERROR: begin
            if (sample) begin
              if (line_se0) begin
                se0_seen <= 1'b1;
              end else if (line_j && se0_seen) begin
                state    <= IDLE;
                se0_seen <= 1'b0;
              end else begin
                se0_seen <= 1'b0;
              end
            end
          end

          default: begin
            state      <= IDLE;
            rcv_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_byte_receiver.sv
// Directed bench for usb_byte_receiver: NRZI/stuffing line encoder drives the
// DUT, expected bytes go through a queue, pulse counts are checked per packet.
module tb_usb_byte_receiver;

  logic       clk = 1'b0;
  logic       n_rst, d_plus, d_minus, rcv_en;
  logic [7:0] byte_out, byte_count;
  logic       byte_valid, sync_detected, eop_detected, rcv_error, rcv_active;

  usb_byte_receiver dut (
    .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus), .rcv_en(rcv_en),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_count(byte_count),
    .sync_detected(sync_detected), .eop_detected(eop_detected),
    .rcv_error(rcv_error), .rcv_active(rcv_active)
  );

  always #5 clk = ~clk;

  int check_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int sync_cnt = 0, eop_cnt = 0, err_cnt = 0, byte_cnt = 0;
  logic [7:0] exp_q[$];
  logic line_j = 1'b1;
  int   ones_run = 0;
  bit   drift_on = 1'b0, drift_alt = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one line state for a number of clocks; edges land 1 time unit after posedge.
  task automatic applyStimulus(input logic dp, input logic dm, input int width);
    d_plus  = dp;
    d_minus = dm;
    repeat (width) @(posedge clk);
    #1;
  endtask

  task automatic get_width(output int w);
    if (drift_on) begin
      drift_alt = !drift_alt;
      w = drift_alt ? 7 : 9;
    end else begin
      w = 8;
    end
  endtask

  task automatic send_raw_bit(input logic b);
    int w;
    get_width(w);
    if (!b) line_j = !line_j;
    applyStimulus(line_j, !line_j, w);
  endtask

  task automatic send_data_bit(input logic b);
    send_raw_bit(b);
    ones_run = b ? ones_run + 1 : 0;
    if (ones_run == 6) begin
      send_raw_bit(1'b0);
      ones_run = 0;
    end
  endtask

  task automatic send_sync();
    line_j = 1'b1;
    for (int i = 0; i < 7; i++) send_raw_bit(1'b0);
    send_raw_bit(1'b1);
    ones_run = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) send_data_bit(b[i]);
  endtask

  task automatic send_eop();
    int w;
    get_width(w);
    applyStimulus(1'b0, 1'b0, w);
    get_width(w);
    applyStimulus(1'b0, 1'b0, w);
    get_width(w);
    applyStimulus(1'b1, 1'b0, w);
    line_j = 1'b1;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b1, 1'b0, n);
    line_j = 1'b1;
  endtask

  // Output monitor away from the active edge: counts pulses, pops expected bytes.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if ((sync_detected | eop_detected | rcv_error | byte_valid) === 1'b1)
        checkOutput("pulse_exclusive",
                    32'($countones({sync_detected, eop_detected, rcv_error, byte_valid})), 32'd1);
      if (sync_detected === 1'b1) sync_cnt++;
      if (eop_detected === 1'b1) eop_cnt++;
      if (rcv_error === 1'b1) err_cnt++;
      if (byte_valid === 1'b1) begin
        byte_cnt++;
        if (exp_q.size() == 0) checkOutput("byte_unexpected", 32'(exp_q.size()), 32'd1);
        else checkOutput("byte_out", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int s0, e0, r0, b0;
    n_rst = 1'b0; rcv_en = 1'b1; d_plus = 1'b0; d_minus = 1'b1;

    // 1: reset with the line toggling
    for (int i = 0; i < 3; i++) begin
      d_plus = i[0]; d_minus = !i[0];
      @(posedge clk);
    end
    #1;
    checkOutput("rst_byte_out", {24'd0, byte_out}, 32'h00);
    checkOutput("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    checkOutput("rst_byte_count", {24'd0, byte_count}, 32'd0);
    checkOutput("rst_sync", {31'd0, sync_detected}, 32'd0);
    checkOutput("rst_eop", {31'd0, eop_detected}, 32'd0);
    checkOutput("rst_error", {31'd0, rcv_error}, 32'd0);
    checkOutput("rst_active", {31'd0, rcv_active}, 32'd0);
    idle(2);
    n_rst = 1'b1;
    idle(20);

    // 2: normal packet
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    send_sync();
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_eop();
    idle(20);
    checkOutput("norm_sync", 32'(sync_cnt - s0), 32'd1);
    checkOutput("norm_bytes", 32'(byte_cnt - b0), 32'd2);
    checkOutput("norm_count", {24'd0, byte_count}, 32'd2);
    checkOutput("norm_eop", 32'(eop_cnt - e0), 32'd1);
    checkOutput("norm_err", 32'(err_cnt - r0), 32'd0);
    checkOutput("norm_active", {31'd0, rcv_active}, 32'd0);

    // 3: bit stuffing inside 0xFF
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h01);
    send_eop();
    idle(20);
    checkOutput("stuff_bytes", 32'(byte_cnt - b0), 32'd2);
    checkOutput("stuff_err", 32'(err_cnt - r0), 32'd0);
    checkOutput("stuff_eop", 32'(eop_cnt - e0), 32'd1);

    // 4: seven ones without stuffing, recovery, fresh packet
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    send_sync();
    for (int i = 0; i < 7; i++) send_raw_bit(1'b1);
    idle(4);
    checkOutput("viol_err", 32'(err_cnt - r0), 32'd1);
    checkOutput("viol_bytes", 32'(byte_cnt - b0), 32'd0);
    send_eop();
    idle(20);
    send_sync();
    send_byte(8'h42);
    send_eop();
    idle(20);
    checkOutput("viol_recover_sync", 32'(sync_cnt - s0), 32'd2);
    checkOutput("viol_recover_eop", 32'(eop_cnt - e0), 32'd1);
    checkOutput("viol_recover_count", {24'd0, byte_count}, 32'd1);

    // 5a: bad sync pattern
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    line_j = 1'b1;
    for (int i = 0; i < 8; i++) send_raw_bit(1'b0);
    send_eop();
    idle(20);
    checkOutput("badsync_err", 32'(err_cnt - r0), 32'd1);
    checkOutput("badsync_sync", 32'(sync_cnt - s0), 32'd0);

    // 5b: SE0 after three data bits
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    send_sync();
    send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
    send_eop();
    idle(20);
    checkOutput("early_eop_err", 32'(err_cnt - r0), 32'd1);
    checkOutput("early_eop_eop", 32'(eop_cnt - e0), 32'd0);
    checkOutput("early_eop_bytes", 32'(byte_cnt - b0), 32'd0);

    // 6a: alternating 7/9 clock bit widths
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    drift_on = 1'b1; drift_alt = 1'b0;
    send_sync();
    send_byte(8'h5A);
    send_eop();
    drift_on = 1'b0;
    idle(20);
    checkOutput("drift_bytes", 32'(byte_cnt - b0), 32'd1);
    checkOutput("drift_err", 32'(err_cnt - r0), 32'd0);
    checkOutput("drift_eop", 32'(eop_cnt - e0), 32'd1);

    // 6b: receive enable dropped mid-byte
    s0 = sync_cnt; e0 = eop_cnt; r0 = err_cnt; b0 = byte_cnt;
    send_sync();
    for (int i = 0; i < 4; i++) send_data_bit(i[0]);
    checkOutput("drop_active_before", {31'd0, rcv_active}, 32'd1);
    rcv_en = 1'b0;
    @(posedge clk); #1;
    checkOutput("drop_active_after", {31'd0, rcv_active}, 32'd0);
    idle(10);
    rcv_en = 1'b1;
    idle(24);
    checkOutput("drop_bytes", 32'(byte_cnt - b0), 32'd0);
    checkOutput("drop_err", 32'(err_cnt - r0), 32'd0);
    checkOutput("drop_eop", 32'(eop_cnt - e0), 32'd0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
